full_adder_reg: RTL and testbench
=================================

Name: full_adder_reg

Overview:
Registered, width-parameterised full adder. Adds two operands and a carry-in, and returns sum and carry-out one clock after the input is accepted. Internally it is a ripple chain of 1-bit full-adder cells with a registered output stage. It serves as an arithmetic leaf cell in datapaths; the default configuration (WIDTH=1) is a classic single-bit full adder.

Parameters:
WIDTH, 1, operand and sum width in bits (legal: 1..64)

Ports:
clk  input  1  single system clock; all state updates on rising edge
rst_n  input  1  synchronous, active-low reset
in_valid  input  1  qualifies a, b, c this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
c  input  1  carry-in
sum  output  WIDTH  registered sum bits
carry  output  1  registered carry-out
out_valid  output  1  high for one cycle when sum/carry hold a new result

Interface notes:
- One clock; reset is synchronous and active-low. Ports are named clk and rst_n.
- No asynchronous paths to outputs; all outputs are driven directly from flops.

Behaviour:
- Reset: on a rising clk edge with rst_n=0, sum=0, carry=0, out_valid=0. Reset wins over in_valid in the same cycle.
- Per-bit cell function, for bit i:
  - s_i = a_i ^ b_i ^ k_i
  - k_(i+1) = (a_i & b_i) | (a_i & k_i) | (b_i & k_i)
  - k_0 = c
- The ripple chain is combinational. Across all bits, {k_WIDTH, s} must equal a + b + c computed at WIDTH+1 bits.
- Capture: on a rising edge with rst_n=1 and in_valid=1:
  - sum <= s
  - carry <= k_WIDTH
  - out_valid <= 1
- Idle: on a rising edge with rst_n=1 and in_valid=0:
  - sum and carry hold their previous values
  - out_valid <= 0
- Latency is exactly 1 cycle, and throughput is one result per cycle. Back-to-back in_valid pulses produce back-to-back results with no bubbles.
- No backpressure; the result is always accepted downstream.
- Overflow wraps: sum holds the low WIDTH bits and carry holds bit WIDTH. No saturation.
- X/Z inputs while in_valid=0 must not disturb the held outputs.
- Reset asserted mid-stream discards any result that would have been captured on that edge. The first valid input after rst_n returns high yields out_valid one cycle later.
- WIDTH=1 truth table (a b c -> carry sum):
  - 000->00, 001->01, 010->01, 011->10
  - 100->01, 101->10, 110->10, 111->11

Test Plan:
- Exhaustive WIDTH=1: apply all 8 {a,b,c} combinations 000..111 with in_valid=1, one per cycle. Each result matches the truth table one cycle later and out_valid stays high throughout.
- Reset: drive rst_n=0 for 2 cycles while applying a=1, b=1, c=1, in_valid=1. Outputs stay sum=0, carry=0, out_valid=0. On the first edge after release, sum=1, carry=1, out_valid=1.
- Hold: capture a=1, b=0, c=1 (sum=0, carry=1), then set in_valid=0 and toggle a/b/c for 5 cycles. sum=0 and carry=1 hold, and out_valid=0.
- WIDTH=8 wrap: a=0xFF, b=0x00, c=1 gives sum=0x00, carry=1. Then a=0x80, b=0x80, c=0 gives sum=0x00, carry=1. Then a=0x12, b=0x34, c=1 gives sum=0x47, carry=0.
- WIDTH=8 random: run 1000 back-to-back random {a,b,c}. Each result equals the reference a+b+c exactly 1 cycle later.
- Mid-stream reset: while streaming, assert rst_n=0 for one cycle. That edge's result is dropped, outputs are zeroed, and streaming resumes correctly afterwards.

Source files
------------

// File: rtl/full_adder_reg.sv
// full_adder_reg: ripple chain of 1-bit full-adder cells whose result is
// captured into an output register stage when in_valid is high. The
// result, sum and carry-out, appears one clock after the input is accepted.
module full_adder_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             out_valid
);

  // Carry chain: k[0] is the carry-in, and k[WIDTH] is the carry-out.
  logic [WIDTH:0]   k;
  logic [WIDTH-1:0] s;

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             carry_d, carry_q;
  logic             out_valid_d, out_valid_q;

  assign k[0] = c;

  // One full-adder cell per bit. The carry ripples upward through k.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      assign s[gi]   = a[gi] ^ b[gi] ^ k[gi];
      assign k[gi+1] = (a[gi] & b[gi]) | (a[gi] & k[gi]) | (b[gi] & k[gi]);
    end
  endgenerate

  // Next-state selection: load a new result on in_valid, otherwise hold it.
  // The operand inputs are not used when in_valid is low.
  always_comb begin
    sum_d       = sum_q;
    carry_d     = carry_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      sum_d       = s;
      carry_d     = k[WIDTH];
      out_valid_d = 1'b1;
    end
  end

  // Output register stage. A synchronous reset takes priority over a capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q       <= '0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sum       = sum_q;
  assign carry     = carry_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_full_adder_reg.sv
// Directed and random testbench for full_adder_reg. It uses one WIDTH=1
// instance and one WIDTH=8 instance. The two instances share the clock,
// the reset, in_valid and the carry-in.
module tb_full_adder_reg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       c;
  logic [0:0] a1, b1, sum1;
  logic       carry1, out_valid1;
  logic [7:0] a8, b8, sum8;
  logic       carry8, out_valid8;

  int checks = 0;
  int errors = 0;

  // Hand-written WIDTH=1 truth table, indexed by {a,b,c}. Each entry is {carry,sum}.
  logic [1:0] tt [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

  always #5 clk = ~clk;

  full_adder_reg #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a1), .b(b1), .c(c),
    .sum(sum1), .carry(carry1), .out_valid(out_valid1)
  );

  full_adder_reg #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a8), .b(b8), .c(c),
    .sum(sum8), .carry(carry8), .out_valid(out_valid8)
  );

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b1;
    a1 = 1'b1; b1 = 1'b1; c = 1'b1; a8 = 8'hFF; b8 = 8'h01;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      $display("reset cycle %0d: w1 c=%b s=%b v=%b w8 c=%b s=%h v=%b",
               i, carry1, sum1, out_valid1, carry8, sum8, out_valid8);
      checks++;
      if ({carry1, sum1, out_valid1} !== 3'b000) begin
        errors++;
        $display("FAIL reset_w1: got c/s/v=%b%b%b want 000", carry1, sum1, out_valid1);
      end
      checks++;
      if ({carry8, sum8, out_valid8} !== 10'b0) begin
        errors++;
        $display("FAIL reset_w8: got c=%b s=%h v=%b want 0 00 0", carry8, sum8, out_valid8);
      end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    $display("reset release: w1 c=%b s=%b v=%b", carry1, sum1, out_valid1);
    checks++;
    if ({carry1, sum1, out_valid1} !== 3'b111) begin
      errors++;
      $display("FAIL release_w1: got c/s/v=%b%b%b want 111", carry1, sum1, out_valid1);
    end
    checks++;
    if ({carry8, sum8, out_valid8} !== {1'b1, 8'h01, 1'b1}) begin
      errors++;
      $display("FAIL release_w8: got c=%b s=%h v=%b want 1 01 1", carry8, sum8, out_valid8);
    end
  endtask

  task automatic test_exhaustive_w1;
    logic [2:0] abc;
    rst_n = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      abc = 3'(i);
      a1 = abc[2]; b1 = abc[1]; c = abc[0];
      @(posedge clk); #1;
      $display("w1 abc=%b -> carry=%b sum=%b valid=%b", abc, carry1, sum1, out_valid1);
      checks++;
      if ({carry1, sum1} !== tt[i]) begin
        errors++;
        $display("FAIL truth_%b: got %b%b want %b", abc, carry1, sum1, tt[i]);
      end
      checks++;
      if (out_valid1 !== 1'b1) begin
        errors++;
        $display("FAIL truth_valid_%b: got %b want 1", abc, out_valid1);
      end
    end
  endtask

  task automatic test_hold;
    in_valid = 1'b1; a1 = 1'b1; b1 = 1'b0; c = 1'b1;
    @(posedge clk); #1;
    $display("hold capture: carry=%b sum=%b valid=%b", carry1, sum1, out_valid1);
    checks++;
    if ({carry1, sum1, out_valid1} !== 3'b101) begin
      errors++;
      $display("FAIL hold_capture: got c/s/v=%b%b%b want 101", carry1, sum1, out_valid1);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a1 = ~a1; b1 = ~b1; c = ~c;
      @(posedge clk); #1;
      $display("hold cycle %0d: carry=%b sum=%b valid=%b", i, carry1, sum1, out_valid1);
      checks++;
      if ({carry1, sum1, out_valid1} !== 3'b100) begin
        errors++;
        $display("FAIL hold_%0d: got c/s/v=%b%b%b want 100", i, carry1, sum1, out_valid1);
      end
    end
  endtask

  task automatic test_wrap_w8;
    logic [7:0] va [3] = '{8'hFF, 8'h80, 8'h12};
    logic [7:0] vb [3] = '{8'h00, 8'h80, 8'h34};
    logic       vc [3] = '{1'b1, 1'b0, 1'b1};
    logic [8:0] ve [3] = '{9'h100, 9'h100, 9'h047};
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a8 = va[i]; b8 = vb[i]; c = vc[i];
      @(posedge clk); #1;
      $display("w8 %h+%h+%b -> carry=%b sum=%h valid=%b", va[i], vb[i], vc[i], carry8, sum8, out_valid8);
      checks++;
      if ({carry8, sum8, out_valid8} !== {ve[i], 1'b1}) begin
        errors++;
        $display("FAIL wrap_%0d: got c=%b s=%h v=%b want %h v=1", i, carry8, sum8, out_valid8, ve[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [8:0] exp;
    in_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); c = 1'($urandom);
      exp = {1'b0, a8} + {1'b0, b8} + {8'b0, c};
      @(posedge clk); #1;
      $display("rand %0d: %h+%h+%b -> %b_%h", i, a8, b8, c, carry8, sum8);
      checks++;
      if ({carry8, sum8, out_valid8} !== {exp, 1'b1}) begin
        errors++;
        $display("FAIL rand_%0d: got c=%b s=%h v=%b want %h v=1", i, carry8, sum8, out_valid8, exp);
      end
    end
  endtask

  task automatic test_midstream_reset;
    in_valid = 1'b1; rst_n = 1'b1;
    a8 = 8'h0F; b8 = 8'hF0; c = 1'b1;
    @(posedge clk); #1;
    $display("mid pre: carry=%b sum=%h valid=%b", carry8, sum8, out_valid8);
    checks++;
    if ({carry8, sum8, out_valid8} !== {9'h100, 1'b1}) begin
      errors++;
      $display("FAIL mid_pre: got c=%b s=%h v=%b want 1 00 1", carry8, sum8, out_valid8);
    end
    rst_n = 1'b0; a8 = 8'h55; b8 = 8'h11; c = 1'b0;
    @(posedge clk); #1;
    $display("mid reset: carry=%b sum=%h valid=%b", carry8, sum8, out_valid8);
    checks++;
    if ({carry8, sum8, out_valid8} !== 10'b0) begin
      errors++;
      $display("FAIL mid_reset: got c=%b s=%h v=%b want 0 00 0", carry8, sum8, out_valid8);
    end
    rst_n = 1'b1; a8 = 8'h10; b8 = 8'h20; c = 1'b1;
    @(posedge clk); #1;
    $display("mid resume0: carry=%b sum=%h valid=%b", carry8, sum8, out_valid8);
    checks++;
    if ({carry8, sum8, out_valid8} !== {9'h031, 1'b1}) begin
      errors++;
      $display("FAIL mid_resume0: got c=%b s=%h v=%b want 0 31 1", carry8, sum8, out_valid8);
    end
    a8 = 8'hC8; b8 = 8'h64; c = 1'b0;
    @(posedge clk); #1;
    $display("mid resume1: carry=%b sum=%h valid=%b", carry8, sum8, out_valid8);
    checks++;
    if ({carry8, sum8, out_valid8} !== {9'h12C, 1'b1}) begin
      errors++;
      $display("FAIL mid_resume1: got c=%b s=%h v=%b want 1 2c 1", carry8, sum8, out_valid8);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({carry8, sum8, out_valid8} !== {9'h12C, 1'b0}) begin
      errors++;
      $display("FAIL mid_idle: got c=%b s=%h v=%b want 1 2c 0", carry8, sum8, out_valid8);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; c = 1'b0;
    a1 = '0; b1 = '0; a8 = '0; b8 = '0;
    @(posedge clk); #1;
    test_reset();
    test_exhaustive_w1();
    test_hold();
    test_wrap_w8();
    test_back_to_back();
    test_midstream_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
